// File: rtl/timer_pkg.sv
// Shared types and constants for the timer bank: prescale select encoding,
// control-byte bit positions and the packed control register layout.
package timer_pkg;

  typedef enum logic [1:0] {
    PRE_1    = 2'd0,
    PRE_64   = 2'd1,
    PRE_256  = 2'd2,
    PRE_1024 = 2'd3
  } prescale_e;

  localparam int CTRL_START   = 7;
  localparam int CTRL_IRQ     = 6;
  localparam int CTRL_CASCADE = 2;

  // Byte layout as written by software: [7] start, [6] irq_en, [2] cascade, [1:0] prescale.
  typedef struct packed {
    logic      start;
    logic      irq_en;
    logic [2:0] rsvd;
    logic      cascade;
    prescale_e prescale;
  } ctrl_t;

  // Channel-select width; a single-channel bank still gets a 1-bit select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_bank_if.sv
// Register-write bus from the memory-mapped I/O block into the timer bank.
interface timer_bank_if #(
  parameter int NUM_TIMERS = 4,
  parameter int WIDTH      = 16
);
  import timer_pkg::*;

  localparam int SEL_W = sel_width(NUM_TIMERS);

  logic [SEL_W-1:0] sel;
  logic             reload_we;
  logic [WIDTH-1:0] reload_wdata;
  logic             ctrl_we;
  logic [7:0]       ctrl_wdata;

  modport master (
    output sel, reload_we, reload_wdata, ctrl_we, ctrl_wdata
  );

  modport slave (
    input sel, reload_we, reload_wdata, ctrl_we, ctrl_wdata
  );

endinterface

// File: rtl/timer_prescaler.sv
// Free-running 10-bit divider shared by all channels; emits one strobe per
// prescale setting (bit index matches the prescale encoding).
module timer_prescaler (
  input  logic       clock_16,
  input  logic       reset,
  output logic [3:0] tick
);

  logic [9:0] div_q;

  // Divider only ever clears on reset so all channels share one phase.
  always_ff @(posedge clock_16 or posedge reset) begin
    if (reset) div_q <= '0;
    else       div_q <= div_q + 10'd1;
  end

  // Strobe on the last count of each power-of-two period.
  always_comb begin
    tick    = '0;
    tick[0] = 1'b1;
    tick[1] = (div_q[5:0] == 6'h3f);
    tick[2] = (div_q[7:0] == 8'hff);
    tick[3] = (div_q == 10'h3ff);
  end

endmodule

// File: rtl/timer_bank.sv
// N-channel up-counting timer bank with reload, start/stop, shared prescaler,
// cascade chaining and registered one-cycle overflow interrupts.
module timer_bank
  import timer_pkg::*;
#(
  parameter int NUM_TIMERS = 4,
  parameter int WIDTH      = 16
) (
  input  logic                        clock_16,
  input  logic                        reset,
  timer_bank_if.slave                 bus,
  output logic [NUM_TIMERS*WIDTH-1:0] count,
  output logic [NUM_TIMERS*8-1:0]     ctrl,
  output logic [NUM_TIMERS-1:0]       irq
);

  localparam int SEL_W = sel_width(NUM_TIMERS);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [3:0]            pre_tick;
  logic [NUM_TIMERS-1:0] hit_ctrl;
  logic [NUM_TIMERS-1:0] hit_reload;
  logic [NUM_TIMERS-1:0] inc;
  logic [NUM_TIMERS-1:0] ovf;

  timer_prescaler u_prescaler (
    .clock_16 (clock_16),
    .reset    (reset),
    .tick     (pre_tick)
  );

  // Write decode plus the per-channel tick/overflow chain. Channels are
  // evaluated in order so a cascade ripple settles within one cycle.
  always_comb begin
    ctrl_t            c;
    logic             ch_tick;
    logic [WIDTH-1:0] cv;
    hit_ctrl   = '0;
    hit_reload = '0;
    inc        = '0;
    ovf        = '0;
    for (int n = 0; n < NUM_TIMERS; n++) begin
      c       = ctrl_t'(ctrl[n*8 +: 8]);
      cv      = count[n*WIDTH +: WIDTH];
      ch_tick = 1'b0;
      hit_ctrl[n]   = bus.ctrl_we   && (bus.sel == SEL_W'(n));
      hit_reload[n] = bus.reload_we && (bus.sel == SEL_W'(n));
      if (c.cascade && (n != 0)) begin
        ch_tick = ovf[n-1];
      end else begin
        case (c.prescale)
          PRE_1:    ch_tick = pre_tick[0];
          PRE_64:   ch_tick = pre_tick[1];
          PRE_256:  ch_tick = pre_tick[2];
          PRE_1024: ch_tick = pre_tick[3];
          default:  ch_tick = 1'b0;
        endcase
      end
      inc[n] = c.start && ch_tick;
      ovf[n] = inc[n] && (cv == ALL_ONES);
    end
  end

  for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_ch
    ctrl_t            ctrl_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] reload_q;
    logic             irq_q;
    logic             start_rise;
    logic             irq_en_now;
    logic [WIDTH-1:0] reload_new;

    // A same-cycle reload write wins over the stored value on a start edge;
    // an irq_en write in the overflow cycle decides that cycle's pulse.
    assign start_rise = hit_ctrl[n] && bus.ctrl_wdata[CTRL_START] && !ctrl_q.start;
    assign reload_new = hit_reload[n] ? bus.reload_wdata : reload_q;
    assign irq_en_now = hit_ctrl[n] ? bus.ctrl_wdata[CTRL_IRQ] : ctrl_q.irq_en;

    // Reload register: written only by software.
    always_ff @(posedge clock_16 or posedge reset) begin
      if (reset)              reload_q <= '0;
      else if (hit_reload[n]) reload_q <= bus.reload_wdata;
    end

    // Control register: full byte kept for readback.
    always_ff @(posedge clock_16 or posedge reset) begin
      if (reset)            ctrl_q <= '0;
      else if (hit_ctrl[n]) ctrl_q <= ctrl_t'(bus.ctrl_wdata);
    end

    // Counter: load on start edge, reload on wrap, otherwise count on tick.
    always_ff @(posedge clock_16 or posedge reset) begin
      if (reset)           cnt_q <= '0;
      else if (start_rise) cnt_q <= reload_new;
      else if (ovf[n])     cnt_q <= reload_q;
      else if (inc[n])     cnt_q <= cnt_q + 1'b1;
    end

    // Interrupt pulse registered from the overflow cycle.
    always_ff @(posedge clock_16 or posedge reset) begin
      if (reset) irq_q <= 1'b0;
      else       irq_q <= ovf[n] && irq_en_now;
    end

    assign count[n*WIDTH +: WIDTH] = cnt_q;
    assign ctrl[n*8 +: 8]          = ctrl_q;
    assign irq[n]                  = irq_q;
  end

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: reset, wrap/irq, prescale alignment,
// cascade ripple, stop/restart, reload write ordering and async reset.
module tb_timer_bank;

   localparam int N = 4;
   localparam int W = 16;

   logic clock_16 = 1'b0;
   logic reset    = 1'b1;
   always #5 clock_16 = ~clock_16;

   logic [N*W-1:0] count;
   logic [N*8-1:0] ctrl;
   logic [N-1:0]   irq;

   timer_bank_if #(.NUM_TIMERS(N), .WIDTH(W)) bus ();

   timer_bank #(.NUM_TIMERS(N), .WIDTH(W)) dut (
      .clock_16 (clock_16),
      .reset    (reset),
      .bus      (bus),
      .count    (count),
      .ctrl     (ctrl),
      .irq      (irq)
   );

   int         n_vec = 0;
   int         n_err = 0;
   logic [9:0] div_m = 10'd0;
   int         k;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock_16);
      if (!reset) div_m = div_m + 10'd1;
      #1;
   endtask

   function automatic logic [W-1:0] cnt(input int n);
      return count[n*W +: W];
   endfunction

   task automatic wr_reload(input int ch, input logic [W-1:0] v);
      bus.sel          = 2'(ch);
      bus.reload_we    = 1'b1;
      bus.reload_wdata = v;
      tick();
      bus.reload_we    = 1'b0;
   endtask

   task automatic wr_ctrl(input int ch, input logic [7:0] v);
      bus.sel        = 2'(ch);
      bus.ctrl_we    = 1'b1;
      bus.ctrl_wdata = v;
      tick();
      bus.ctrl_we    = 1'b0;
   endtask

   initial begin
      bus.sel          = '0;
      bus.reload_we    = 1'b0;
      bus.reload_wdata = '0;
      bus.ctrl_we      = 1'b0;
      bus.ctrl_wdata   = '0;

      repeat (3) tick();
      chk("rst_count", count, 64'h0);
      chk("rst_ctrl", ctrl, 32'h0);
      chk("rst_irq", irq, 4'h0);
      reset = 1'b0;

      // wrap and irq timing on channel 0, prescale 1
      wr_reload(0, 16'hFFFE);
      wr_ctrl(0, 8'hC0);
      chk("ctrl0_readback", ctrl[7:0], 8'hC0);
      chk("start_load", cnt(0), 16'hFFFE);
      chk("start_irq0", irq[0], 1'b0);
      tick();
      chk("inc_ffff", cnt(0), 16'hFFFF);
      chk("no_irq_yet", irq[0], 1'b0);
      tick();
      chk("wrap_reload", cnt(0), 16'hFFFE);
      chk("irq_after_wrap", irq[0], 1'b1);
      tick();
      chk("irq_one_cycle", irq[0], 1'b0);
      chk("inc_ffff_2", cnt(0), 16'hFFFF);
      wr_ctrl(0, 8'h80);
      chk("irq_en_off_suppress", irq[0], 1'b0);
      chk("wrap_no_irq", cnt(0), 16'hFFFE);
      tick();
      chk("inc_ffff_3", cnt(0), 16'hFFFF);
      wr_ctrl(0, 8'h40);
      chk("stop_keeps_irq", irq[0], 1'b1);
      tick();
      chk("stopped_hold", cnt(0), 16'hFFFE);
      chk("stopped_no_irq", irq[0], 1'b0);

      // back-to-back overflows on channel 3
      wr_reload(3, 16'hFFFF);
      wr_ctrl(3, 8'hC0);
      chk("b2b_load", cnt(3), 16'hFFFF);
      tick();
      chk("b2b_irq_a", irq[3], 1'b1);
      tick();
      chk("b2b_irq_b", irq[3], 1'b1);
      wr_ctrl(3, 8'h00);
      tick();
      chk("b2b_end", irq[3], 1'b0);

      // prescale 64 then 1024 on channel 1
      wr_reload(1, 16'h0000);
      wr_ctrl(1, 8'h81);
      chk("pre64_load", cnt(1), 16'h0000);
      k = 0;
      while (cnt(1) == 16'h0000 && k < 200) begin tick(); k++; end
      chk("pre64_align", div_m[5:0], 6'd0);
      chk("pre64_first", cnt(1), 16'h0001);
      repeat (63) tick();
      chk("pre64_hold63", cnt(1), 16'h0001);
      tick();
      chk("pre64_second", cnt(1), 16'h0002);
      wr_ctrl(1, 8'h83);
      chk("rewrite_untouched", cnt(1), 16'h0002);
      k = 0;
      while (cnt(1) == 16'h0002 && k < 1100) begin tick(); k++; end
      chk("pre1024_align", div_m, 10'd0);
      chk("pre1024_inc", cnt(1), 16'h0003);
      wr_ctrl(1, 8'h00);

      // cascade ch0 -> ch1 -> ch2
      wr_reload(1, 16'h0000);
      wr_ctrl(1, 8'h84);
      wr_reload(0, 16'hFFFF);
      wr_ctrl(0, 8'h80);
      chk("casc_ch0_load", cnt(0), 16'hFFFF);
      chk("casc_ch1_load", cnt(1), 16'h0000);
      tick();
      chk("casc_ch1_1", cnt(1), 16'h0001);
      tick();
      chk("casc_ch1_2", cnt(1), 16'h0002);
      wr_ctrl(0, 8'h00);
      wr_ctrl(1, 8'h04);
      chk("casc_ch1_stop", cnt(1), 16'h0003);
      wr_reload(1, 16'hFFFF);
      wr_ctrl(1, 8'h84);
      wr_reload(2, 16'h0010);
      wr_ctrl(2, 8'h84);
      wr_ctrl(0, 8'h80);
      chk("ripple_pre", cnt(2), 16'h0010);
      tick();
      chk("ripple_ch0", cnt(0), 16'hFFFF);
      chk("ripple_ch1", cnt(1), 16'hFFFF);
      chk("ripple_ch2", cnt(2), 16'h0011);
      tick();
      chk("ripple_ch2_b", cnt(2), 16'h0012);
      wr_ctrl(0, 8'h00);
      wr_ctrl(1, 8'h00);
      wr_ctrl(2, 8'h00);

      // stop at 0x1234, hold, restart reloads
      wr_reload(2, 16'h1230);
      wr_ctrl(2, 8'h80);
      repeat (3) tick();
      wr_ctrl(2, 8'h00);
      chk("stop_at", cnt(2), 16'h1234);
      repeat (100) tick();
      chk("stop_hold100", cnt(2), 16'h1234);
      wr_ctrl(2, 8'h80);
      chk("restart_reload", cnt(2), 16'h1230);

      // same-cycle reload + start uses the new reload
      bus.sel          = 2'd3;
      bus.reload_we    = 1'b1;
      bus.reload_wdata = 16'hABCD;
      bus.ctrl_we      = 1'b1;
      bus.ctrl_wdata   = 8'h80;
      tick();
      bus.reload_we    = 1'b0;
      bus.ctrl_we      = 1'b0;
      chk("same_cycle_load", cnt(3), 16'hABCD);

      // reload written while running applies only at next wrap
      wr_ctrl(2, 8'h00);
      wr_reload(2, 16'hFFFD);
      wr_ctrl(2, 8'h80);
      chk("late_reload_start", cnt(2), 16'hFFFD);
      wr_reload(2, 16'h0100);
      chk("late_reload_ignored", cnt(2), 16'hFFFE);
      tick();
      chk("late_reload_ffff", cnt(2), 16'hFFFF);
      tick();
      chk("late_reload_at_ovf", cnt(2), 16'h0100);

      // async reset with irq high
      wr_ctrl(0, 8'hC0);
      tick();
      chk("pre_reset_irq", irq[0], 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_count", count, 64'h0);
      chk("async_rst_irq", irq, 4'h0);
      chk("async_rst_ctrl", ctrl, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
